// File: rtl/dmem_if.sv
// dmem_if: request/response channel bundle between a requester and dmem_pipe.
interface dmem_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) ();
  logic                  req_valid_i;
  logic                  req_ready_o;
  logic                  req_we_i;
  logic [1:0]            req_size_i;
  logic                  req_unsigned_i;
  logic [ADDR_WIDTH-1:0] req_addr_i;
  logic [DATA_WIDTH-1:0] req_wdata_i;
  logic                  rsp_valid_o;
  logic                  rsp_ready_i;
  logic [DATA_WIDTH-1:0] rsp_rdata_o;
  logic [1:0]            rsp_err_o;
  modport slave (
    input  req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
  );
  modport master (
    output req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
  );
endinterface

// File: rtl/dmem_pipe.sv
// dmem_pipe: byte-addressable data memory with fixed access latency, load extension
// and error reporting over a valid/ready request/response pair.
module dmem_pipe #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_BYTES = 4096,
  parameter int ADDR_WIDTH  = 32,
  parameter int LATENCY     = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  dmem_if.slave       bus,
  output logic [15:0] err_cnt_o
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int LANEW = $clog2(BYTES);
  localparam int WORDS = DEPTH_BYTES / BYTES;
  localparam int IDXW  = $clog2(WORDS);
  localparam int BITW  = $clog2(DATA_WIDTH);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t                state_q, state_d;
  logic                  we_q, we_d, uns_q, uns_d;
  logic [1:0]            size_q, size_d, cnt_q, cnt_d, err_q, err_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [15:0]           err_cnt_q, err_cnt_d;
  logic [DATA_WIDTH-1:0] mem [WORDS];
  logic [ADDR_WIDTH:0]   acc_bytes;
  logic [1:0]            err;
  logic [IDXW-1:0]       idx;
  logic [LANEW-1:0]      lane;
  logic [DATA_WIDTH-1:0] sh, keep, ld, wd;
  logic [BYTES-1:0]      be;
  logic [7:0]            nb;
  logic [BITW-1:0]       top;
  logic                  sgn, commit;
  always_comb begin
    acc_bytes = (ADDR_WIDTH+1)'(1) << size_q;
    idx       = addr_q[LANEW +: IDXW];
    lane      = addr_q[LANEW-1:0];
    // Bounds test is done one bit wider so addresses near the top cannot wrap into range.
    err = (size_q == 2'd3 && DATA_WIDTH == 32) ? 2'd3 :
          |(addr_q & (acc_bytes[ADDR_WIDTH-1:0] - 1'b1)) ? 2'd1 :
          ({1'b0, addr_q} + acc_bytes > (ADDR_WIDTH+1)'(DEPTH_BYTES)) ? 2'd2 : 2'd0;
    sh   = mem[idx] >> {lane, 3'b000};
    nb   = (size_q == 2'd3 || (size_q == 2'd2 && DATA_WIDTH == 32)) ? 8'(DATA_WIDTH) : 8'd8 << size_q;
    top  = BITW'(nb - 8'd1);
    keep = ~({DATA_WIDTH{1'b1}} << nb);
    sgn  = ~uns_q & sh[top];
    ld   = (sh & keep) | ({DATA_WIDTH{sgn}} & ~keep);
    be   = ~({BYTES{1'b1}} << acc_bytes[3:0]) << lane;
    wd   = wdata_q << {lane, 3'b000};
    commit = state_q == ACCESS && cnt_q == 2'd0 && we_q && err == 2'd0;
  end
  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    uns_d     = uns_q;
    size_d    = size_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    err_cnt_d = err_cnt_q;
    case (state_q)
      IDLE: if (bus.req_valid_i) begin
        we_d    = bus.req_we_i;
        uns_d   = bus.req_unsigned_i;
        size_d  = bus.req_size_i;
        addr_d  = bus.req_addr_i;
        wdata_d = bus.req_wdata_i;
        cnt_d   = 2'(LATENCY - 1);
        state_d = ACCESS;
      end
      ACCESS: if (cnt_q == 2'd0) begin
        rdata_d   = (err == 2'd0 && !we_q) ? ld : '0;
        err_d     = err;
        err_cnt_d = err_cnt_q + {15'd0, err != 2'd0 && err_cnt_q != 16'hFFFF};
        state_d   = RESP;
      end else cnt_d = cnt_q - 2'd1;
      default: if (bus.rsp_ready_i) state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q   <= IDLE;
      we_q      <= 1'b0;
      uns_q     <= 1'b0;
      size_q    <= 2'd0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cnt_q     <= 2'd0;
      rdata_q   <= '0;
      err_q     <= 2'd0;
      err_cnt_q <= 16'd0;
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      uns_q     <= uns_d;
      size_q    <= size_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      cnt_q     <= cnt_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  // Storage is deliberately outside the reset domain; commit is gated by the reset FSM.
  always_ff @(posedge clk)
    for (int b = 0; b < BYTES; b++)
      if (commit && be[b]) mem[idx][8*b +: 8] <= wd[8*b +: 8];
  assign bus.req_ready_o = state_q == IDLE;
  assign bus.rsp_valid_o = state_q == RESP;
  assign bus.rsp_rdata_o = rdata_q;
  assign bus.rsp_err_o   = err_q;
  assign err_cnt_o       = err_cnt_q;
endmodule
